multibuffer_write_arbiter: RTL and testbench
============================================

// Module: multibuffer_write_arbiter
// PURPOSE
//   Shares the single write port of multibuffer_queue among NUM_REQ producers.
//   Round-robin grant with a one-entry registered output stage. Drives
//   q_write_en/q_data_in and honours the queue's q_waitrequest backpressure.
//   Sits between the producer engines and the multibuffer_queue write side.
// PARAMETERS
//   NUM_REQ       4    number of requesters (2..8)
//   Q_DATA_WIDTH  128  line width; must match multibuffer_queue Q_DATA_WIDTH
//   ID_WIDTH      2    grant id width; must be >= clog2(NUM_REQ)
//   MAX_BURST     4    beats per grant; used only when BURST_LOCK_EN is defined
// PORTS
//   clk            in   1                  clock, rising edge
//   rst            in   1                  asynchronous, active-high reset
//   req_valid      in   NUM_REQ            per-requester line valid
//   req_data       in   NUM_REQ*Q_DATA_W   requester i occupies bits [i*Q+:Q]
//   req_ready      out  NUM_REQ            one-hot or zero; beat taken on valid&ready
//   q_write_en     out  1                  to queue write_en
//   q_data_in      out  Q_DATA_WIDTH       to queue data_in
//   q_waitrequest  in   1                  from queue; write accepted iff en & !wait
//   grant_id       out  ID_WIDTH           source id of the beat in the output reg
// BEHAVIOUR
//   - Reset values: q_write_en=0, q_data_in=0, grant_id=0, req_ready=0 while rst.
//     last_grant is reset to NUM_REQ-1, so requester 0 has first priority.
//   - out_free = !q_write_en | !q_waitrequest, i.e. the output reg is empty or
//     drains this cycle. req_ready is 0 for every requester when !out_free.
//   - Arbitration (combinational): scan from last_grant+1 upward with wrap, then
//     pick the first requester with req_valid. Assert req_ready for that one only.
//   - On a transfer: at the next edge q_write_en=1, q_data_in=req_data[winner],
//     grant_id=winner, last_grant=winner. Latency is 1 cycle from request to write.
//   - With no transfer and a drain (q_write_en & !q_waitrequest): q_write_en->0.
//     q_data_in and grant_id hold their values.
//   - q_write_en & q_waitrequest: q_write_en, q_data_in and grant_id are held
//     stable. No beat is ever dropped or duplicated.
//   - Back-to-back: drain and a new accept in the same cycle keep q_write_en=1.
//     This gives 1 beat/cycle throughput.
//   - Fairness: each valid requester is granted within NUM_REQ beats, or within
//     NUM_REQ*MAX_BURST beats when BURST_LOCK_EN is defined.
//   - A requester that drops req_valid before ready loses nothing. Its priority
//     position is unchanged.
//   - Reset mid-operation: the pending output beat is discarded. All state
//     returns to its reset values asynchronously.
//   - Ordering: beats from one requester reach the queue in acceptance order.
// CONFIGURATION
//   BURST_LOCK_EN defined:
//     - The grant stays with the current owner while it keeps req_valid high,
//       for up to MAX_BURST consecutive transfers.
//     - A 3-bit beat counter is reset on each owner change.
//     - Priority rotates when the owner deasserts valid or after MAX_BURST beats.
//   BURST_LOCK_EN undefined:
//     - Pure per-beat round robin. No burst counter is implemented.
//     - MAX_BURST is ignored.
// TESTING
//   1. Reset: rst=1 with all req_valid=1 -> q_write_en=0 and req_ready=0.
//      After release, the first grant goes to id 0.
//   2. All 4 valid, q_waitrequest=0, no macro -> grant_id sequence 0,1,2,3,0.
//      q_write_en high every cycle; q_data_in equals the matching req_data slice.
//   3. Single requester 2 with 8 beats 0xA0..0xA7 -> same order at q_data_in.
//      Latency is 1 cycle.
//   4. Hold q_waitrequest=1 for 5 cycles while a beat is pending.
//      q_data_in and grant_id must be stable; req_ready stays 0.
//      After release, exactly one write occurs, then the next grant.
//   5. BURST_LOCK_EN, MAX_BURST=4, req 0 and 1 both always valid.
//      Required grant pattern: 0,0,0,0,1,1,1,1,0.
//   6. Assert rst for 1 cycle mid-stream with a beat pending.
//      q_write_en falls immediately (async); afterwards grant restarts at id 0.

Source files
------------

// File: rtl/multibuffer_write_arbiter.sv
// Round-robin arbiter sharing the multibuffer_queue write port among NUM_REQ producers.
// Optional burst locking of the grant is enabled by defining BURST_LOCK_EN.
module multibuffer_write_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int Q_DATA_WIDTH = 128,
  parameter int ID_WIDTH     = 2,
  parameter int MAX_BURST    = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*Q_DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              q_write_en,
  output logic [Q_DATA_WIDTH-1:0]           q_data_in,
  input  logic                              q_waitrequest,
  output logic [ID_WIDTH-1:0]               grant_id
);

  localparam int unsigned NR = NUM_REQ;
  localparam int unsigned MB = MAX_BURST;
  localparam int unsigned IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || ID_WIDTH < $clog2(NUM_REQ) ||
      MAX_BURST < 1 || MAX_BURST > 7) begin : g_bad_params
    $error("multibuffer_write_arbiter: illegal parameter combination");
  end

  logic [Q_DATA_WIDTH-1:0] req_data_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_data_a[g] = req_data[g*Q_DATA_WIDTH +: Q_DATA_WIDTH];
  end

  logic                    q_write_en_q, q_write_en_d;
  logic [Q_DATA_WIDTH-1:0] q_data_in_q,  q_data_in_d;
  logic [ID_WIDTH-1:0]     grant_id_q,   grant_id_d;
  logic [IW-1:0]           last_grant_q, last_grant_d;

`ifdef BURST_LOCK_EN
  logic [2:0]              burst_cnt_q,  burst_cnt_d;
`endif

  logic                    out_free;
  logic                    found;
  logic                    transfer;
  logic [IW-1:0]           winner;
  logic [IW-1:0]           sel;
  int unsigned             idx;

  always_comb begin
    out_free = !q_write_en_q || !q_waitrequest;
    found    = 1'b0;
    winner   = '0;
    sel      = '0;
    idx      = 0;

`ifdef BURST_LOCK_EN
    // An active burst keeps the grant until the owner drops valid or hits MAX_BURST.
    if (req_valid[last_grant_q] && burst_cnt_q != '0 && 32'(burst_cnt_q) < MB) begin
      found  = 1'b1;
      winner = last_grant_q;
    end
`endif

    for (int unsigned i = 0; i < NR; i++) begin
      idx = (32'(last_grant_q) + 1 + i) % NR;
      sel = IW'(idx);
      if (!found && req_valid[sel]) begin
        found  = 1'b1;
        winner = sel;
      end
    end

    transfer  = out_free && found;
    req_ready = '0;
    if (transfer && !rst) begin
      req_ready[winner] = 1'b1;
    end

    q_write_en_d = q_write_en_q;
    q_data_in_d  = q_data_in_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;

    if (transfer) begin
      q_write_en_d = 1'b1;
      q_data_in_d  = req_data_a[winner];
      grant_id_d   = ID_WIDTH'(winner);
      last_grant_d = winner;
    end else if (q_write_en_q && !q_waitrequest) begin
      q_write_en_d = 1'b0;
    end

`ifdef BURST_LOCK_EN
    burst_cnt_d = burst_cnt_q;
    if (transfer) begin
      if (winner == last_grant_q && 32'(burst_cnt_q) < MB) begin
        burst_cnt_d = burst_cnt_q + 3'd1;
      end else begin
        burst_cnt_d = 3'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_write_en_q <= 1'b0;
      q_data_in_q  <= '0;
      grant_id_q   <= '0;
      last_grant_q <= IW'(NR - 1);
`ifdef BURST_LOCK_EN
      burst_cnt_q  <= '0;
`endif
    end else begin
      q_write_en_q <= q_write_en_d;
      q_data_in_q  <= q_data_in_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
`ifdef BURST_LOCK_EN
      burst_cnt_q  <= burst_cnt_d;
`endif
    end
  end

  assign q_write_en = q_write_en_q;
  assign q_data_in  = q_data_in_q;
  assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_multibuffer_write_arbiter.sv
// Directed self-checking bench for multibuffer_write_arbiter (NUM_REQ=4, 128-bit lines).
module tb_multibuffer_write_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [511:0] req_data;
  logic [3:0]   req_ready;
  logic         q_write_en;
  logic [127:0] q_data_in;
  logic         q_waitrequest;
  logic [1:0]   grant_id;

  logic [127:0] dat [4];
  int           errors = 0;
  int           checks = 0;
  int           wr_count = 0;
  int           wr_snap;

  multibuffer_write_arbiter #(
    .NUM_REQ      (4),
    .Q_DATA_WIDTH (128),
    .ID_WIDTH     (2),
    .MAX_BURST    (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .q_write_en    (q_write_en),
    .q_data_in     (q_data_in),
    .q_waitrequest (q_waitrequest),
    .grant_id      (grant_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && q_write_en && !q_waitrequest) wr_count <= wr_count + 1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    req_data = {dat[3], dat[2], dat[1], dat[0]};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp_seq [9];
  int n_seq;
  int exp6;

  initial begin
    for (int i = 0; i < 4; i++) dat[i] = 128'hC0DE_0000_0000_0000_0000_0000_0000_0010 + 128'(i);
    drive();
    rst = 1'b1;
    req_valid = 4'hF;
    q_waitrequest = 1'b0;

    // 1. Reset
    #12;
    chk("rst_we",    128'(q_write_en), 128'd0);
    chk("rst_ready", 128'(req_ready),  128'd0);
    chk("rst_id",    128'(grant_id),   128'd0);
    chk("rst_data",  q_data_in,        128'd0);
    step();
    rst = 1'b0;
    #1;
    chk("first_ready", 128'(req_ready), 128'h1);

    // 2. All valid: grants 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_we",    128'(q_write_en), 128'd1);
      chk("rr_id",    128'(grant_id),   128'(k % 4));
      chk("rr_data",  q_data_in,        dat[k % 4]);
      chk("rr_ready", 128'(req_ready),  128'(4'b0001 << ((k + 1) % 4)));
    end
    req_valid = 4'h0;
    step();
    chk("drain_we",   128'(q_write_en), 128'd0);
    chk("drain_id",   128'(grant_id),   128'd0);
    chk("drain_data", q_data_in,        dat[0]);

    // 3. Single requester 2, eight beats in order
    req_valid = 4'b0100;
    for (int k = 0; k < 8; k++) begin
      dat[2] = 128'hA0 + 128'(k);
      drive();
      #1;
      chk("single_ready", 128'(req_ready), 128'h4);
      step();
      chk("single_we",   128'(q_write_en), 128'd1);
      chk("single_id",   128'(grant_id),   128'd2);
      chk("single_data", q_data_in,        128'hA0 + 128'(k));
    end
    req_valid = 4'h0;
    step();
    chk("single_drain", 128'(q_write_en), 128'd0);

    // 4. Backpressure hold
    dat[1] = 128'h11;
    dat[3] = 128'h33;
    drive();
    req_valid = 4'b1010;
    step();
    chk("bp_id0",   128'(grant_id), 128'd3);
    chk("bp_data0", q_data_in,      128'h33);
    q_waitrequest = 1'b1;
    #1;
    chk("bp_ready0", 128'(req_ready), 128'd0);
    wr_snap = wr_count;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_we",    128'(q_write_en), 128'd1);
      chk("bp_id",    128'(grant_id),   128'd3);
      chk("bp_data",  q_data_in,        128'h33);
      chk("bp_ready", 128'(req_ready),  128'd0);
    end
    q_waitrequest = 1'b0;
    #1;
    chk("bp_rel_ready", 128'(req_ready), 128'h2);
    step();
    chk("bp_one_write", 128'(wr_count - wr_snap), 128'd1);
    chk("bp_next_id",   128'(grant_id),           128'd1);
    chk("bp_next_data", q_data_in,                128'h11);
    req_valid = 4'h0;
    step();
    chk("bp_two_writes", 128'(wr_count - wr_snap), 128'd2);
    chk("bp_drain_we",   128'(q_write_en),         128'd0);

    // 5. Requesters 0 and 1 continuously valid
`ifdef BURST_LOCK_EN
    exp_seq = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    n_seq = 9;
    exp6 = 0;
`else
    exp_seq = '{0, 1, 0, 1, 0, 0, 0, 0, 0};
    n_seq = 5;
    exp6 = 1;
`endif
    dat[0] = 128'h500;
    dat[1] = 128'h501;
    drive();
    req_valid = 4'b0011;
    for (int k = 0; k < n_seq; k++) begin
      step();
      chk("pair_id",   128'(grant_id), 128'(exp_seq[k]));
      chk("pair_data", q_data_in,      dat[exp_seq[k]]);
    end
    req_valid = 4'h0;
    step();
    chk("pair_drain_we", 128'(q_write_en), 128'd0);

    // 6. Reset mid-stream with a beat pending
    req_valid = 4'hF;
    step();
    chk("mid_id", 128'(grant_id),   128'(exp6));
    chk("mid_we", 128'(q_write_en), 128'd1);
    q_waitrequest = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_we",    128'(q_write_en), 128'd0);
    chk("mid_rst_ready", 128'(req_ready),  128'd0);
    chk("mid_rst_id",    128'(grant_id),   128'd0);
    chk("mid_rst_data",  q_data_in,        128'd0);
    #1;
    rst = 1'b0;
    q_waitrequest = 1'b0;
    #1;
    chk("post_rst_ready", 128'(req_ready), 128'h1);
    step();
    chk("post_rst_we",   128'(q_write_en), 128'd1);
    chk("post_rst_id",   128'(grant_id),   128'd0);
    chk("post_rst_data", q_data_in,        dat[0]);
    req_valid = 4'h0;
    step();
    chk("post_rst_drain", 128'(q_write_en), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
